rf_scoreboard_file: RTL



---
 rtl/mips_pkg.sv | 14 +
 rtl/rf_scoreboard_file_if.sv | 29 ++
 rtl/rf_pending_tracker.sv | 52 +++++
 rtl/rf_scoreboard_file.sv | 74 +++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: register file size defaults, the
// hardwired-zero register address and the popcount width helper.
package mips_pkg;

  localparam int AWL_DEF  = 5;
  localparam int DWL_DEF  = 32;
  localparam int REG_ZERO = 0;

  // Bits needed to count every entry of a 2**awl deep vector (0..2**awl).
  function automatic int pcnt_width(input int awl);
    return $clog2((1 << awl) + 1);
  endfunction

endpackage

// File: rtl/rf_scoreboard_file_if.sv
// Decode-stage register file bus: writeback port, N read ports, issue
// port and the scoreboard outputs feeding the hazard/stall unit.
interface rf_scoreboard_file_if #(
  parameter int AWL = 5,
  parameter int DWL = 32,
  parameter int NRP = 2
);

  logic               RFWE;
  logic [AWL-1:0]     RFWA;
  logic [DWL-1:0]     RFWD;
  logic [NRP*AWL-1:0] RFRA;
  logic [NRP*DWL-1:0] RFRD;
  logic               ISSUE;
  logic [AWL-1:0]     ISSUEA;
  logic [NRP-1:0]     RFBUSY;
  logic [AWL:0]       RFPEND;

  modport master (
    output RFWE, RFWA, RFWD, RFRA, ISSUE, ISSUEA,
    input  RFRD, RFBUSY, RFPEND
  );

  modport slave (
    input  RFWE, RFWA, RFWD, RFRA, ISSUE, ISSUEA,
    output RFRD, RFBUSY, RFPEND
  );

endinterface

// File: rtl/rf_pending_tracker.sv
// Pending-write scoreboard: one bit per register, cleared at writeback
// and set at issue (set wins on a same-address collision), plus a
// registered count of outstanding registers.
module rf_pending_tracker
  import mips_pkg::*;
#(
  parameter int AWL = AWL_DEF
) (
  input  logic                       CLK,
  input  logic                       RSTN,
  input  logic                       clr_en,
  input  logic [AWL-1:0]             clr_addr,
  input  logic                       set_en,
  input  logic [AWL-1:0]             set_addr,
  output logic [(1<<AWL)-1:0]        pending,
  output logic [pcnt_width(AWL)-1:0] pend_cnt
);

  localparam int DEPTH = 1 << AWL;
  localparam int CW    = pcnt_width(AWL);

  logic [DEPTH-1:0] pend_nxt;
  logic [CW-1:0]    cnt_nxt;

  // Next pending vector: clear first, then set, so the younger issue wins.
  always_comb begin
    pend_nxt = pending;
    if (clr_en && (clr_addr != AWL'(REG_ZERO))) pend_nxt[clr_addr] = 1'b0;
    if (set_en && (set_addr != AWL'(REG_ZERO))) pend_nxt[set_addr] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  // Population count of the next vector so the count register tracks pending exactly.
  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_nxt = cnt_nxt + CW'(pend_nxt[i]);
    end
  end

  // Pending vector and count update together on the clock edge.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      pending  <= '0;
      pend_cnt <= '0;
    end else begin
      pending  <= pend_nxt;
      pend_cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/rf_scoreboard_file.sv
// Decode-stage register file: 2**AWL x DWL storage, NRP combinational
// read ports, one synchronous write port, hardwired-zero r0 and an
// integrated pending-write scoreboard.
// Build option: RF_BYPASS_EN makes reads write-first (writeback data and
// a cleared busy flag are visible in the writeback cycle itself).
module rf_scoreboard_file
  import mips_pkg::*;
#(
  parameter int AWL = AWL_DEF,
  parameter int DWL = DWL_DEF,
  parameter int NRP = 2
) (
  input logic                 CLK,
  input logic                 RSTN,
  rf_scoreboard_file_if.slave bus
);

  localparam int DEPTH = 1 << AWL;

  logic [DWL-1:0]             mem [DEPTH];
  logic [DEPTH-1:0]           pending;
  logic [pcnt_width(AWL)-1:0] pend_cnt;
  logic [NRP*DWL-1:0]         rd_flat;
  logic [NRP-1:0]             busy;
  logic [AWL-1:0]             ra;
  logic                       wr_ok;

  assign wr_ok = bus.RFWE && (bus.RFWA != AWL'(REG_ZERO));

  // Storage array; whole array clears on reset so every read returns 0.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[bus.RFWA] <= bus.RFWD;
    end
  end

  rf_pending_tracker #(.AWL(AWL)) u_tracker (
    .CLK      (CLK),
    .RSTN     (RSTN),
    .clr_en   (bus.RFWE),
    .clr_addr (bus.RFWA),
    .set_en   (bus.ISSUE),
    .set_addr (bus.ISSUEA),
    .pending  (pending),
    .pend_cnt (pend_cnt)
  );

  // Read muxes and per-port busy flags, with optional writeback bypass.
  always_comb begin
    rd_flat = '0;
    busy    = '0;
    ra      = '0;
    for (int i = 0; i < NRP; i++) begin
      ra = bus.RFRA[i*AWL +: AWL];
      if (ra != AWL'(REG_ZERO)) begin
        rd_flat[i*DWL +: DWL] = mem[ra];
        busy[i]               = pending[ra];
`ifdef RF_BYPASS_EN
        if (bus.RFWE && (bus.RFWA == ra)) begin
          rd_flat[i*DWL +: DWL] = bus.RFWD;
          busy[i]               = 1'b0;
        end
`endif
      end
    end
  end

  assign bus.RFRD   = rd_flat;
  assign bus.RFBUSY = busy;
  assign bus.RFPEND = pend_cnt;

endmodule
